rc5_core: RTL and testbench

Parametrised RC5 block-cipher core: it encrypts or decrypts one 2W-bit block using a round-key table that software loads. It is the successor to the fixed 16-bit encrypt-only RC5 engine and plugs into the same start/done datapath slot. Word width, round count and direction are all configurable. The core computes one RC5 half-round pair per clock.

---
 rtl/rc5_core.sv | 175 +++++++++++++++++
 tb/tb_rc5_core.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc5_core.sv
`default_nettype none
// ============================================================================
// Module   : rc5_core
// Brief    : RC5 block cipher core, one round step per clock, loadable key
//            table. Decrypt support is built in when RC5_CORE_DECRYPT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module rc5_core #(
  parameter int W   = 16,
  parameter int R   = 12,
  parameter int LGW = $clog2(W),
  parameter int NK  = 2*R+2
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic           mode,
  input  logic [2*W-1:0] p,
  output logic [2*W-1:0] c,
  output logic           done,
  output logic           busy,
  input  logic           sk_we,
  input  logic [7:0]     sk_addr,
  input  logic [W-1:0]   sk_wdata
);

  localparam int KAW = $clog2(NK);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [7:0]     k_q, k_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [2*W-1:0] c_q, c_d;
  logic           done_q, done_d;
  logic [W-1:0]   sk_q [NK];
  logic [W-1:0]   sk_d [NK];

  logic           last_step;
  logic [W-1:0]   step_a, step_b;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LGW-1:0] s);
    return (x << s) | (x >> (W - int'(s)));
  endfunction

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [LGW-1:0] s);
    return (x >> s) | (x << (W - int'(s)));
  endfunction

  assign last_step = (k_q == 8'(R));

  // Encrypt step k uses S[2k], S[2k+1]; step 0 is the plain key addition.
  logic [KAW-1:0] enc_lo, enc_hi;
  logic [W-1:0]   enc_a, enc_b;

  assign enc_lo = KAW'({k_q, 1'b0});
  assign enc_hi = KAW'({k_q, 1'b1});

  always_comb begin
    enc_a = a_q + sk_q[enc_lo];
    enc_b = b_q + sk_q[enc_hi];
    if (k_q != 8'd0) begin
      enc_a = rotl(a_q ^ b_q, b_q[LGW-1:0]) + sk_q[enc_lo];
      enc_b = rotl(b_q ^ enc_a, enc_a[LGW-1:0]) + sk_q[enc_hi];
    end
  end

`ifdef RC5_CORE_DECRYPT_EN
  logic           mode_q, mode_d;
  logic [7:0]     dec_i;
  logic [KAW-1:0] dec_lo, dec_hi;
  logic [W-1:0]   dec_a, dec_b;

  // Decrypt walks the key table backwards: round index i = R - k.
  assign dec_i  = 8'(R) - k_q;
  assign dec_lo = KAW'({dec_i, 1'b0});
  assign dec_hi = KAW'({dec_i, 1'b1});

  always_comb begin
    dec_b = b_q - sk_q[dec_hi];
    dec_a = a_q - sk_q[dec_lo];
    if (!last_step) begin
      dec_b = rotr(b_q - sk_q[dec_hi], a_q[LGW-1:0]) ^ a_q;
      dec_a = rotr(a_q - sk_q[dec_lo], dec_b[LGW-1:0]) ^ dec_b;
    end
  end

  assign step_a = mode_q ? dec_a : enc_a;
  assign step_b = mode_q ? dec_b : enc_b;
`else
  logic w_unused_mode;
  assign w_unused_mode = mode;
  assign step_a        = enc_a;
  assign step_b        = enc_b;
`endif

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    done_d  = 1'b0;
    sk_d    = sk_q;
`ifdef RC5_CORE_DECRYPT_EN
    mode_d  = mode_q;
`endif

    if (sk_we && !busy && ({2'b00, sk_addr} < 10'(NK))) begin
      sk_d[KAW'(sk_addr)] = sk_wdata;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          k_d     = 8'd0;
          a_d     = p[W-1:0];
          b_d     = p[2*W-1:W];
`ifdef RC5_CORE_DECRYPT_EN
          mode_d  = mode;
`endif
        end
      end
      default: begin
        a_d = step_a;
        b_d = step_b;
        if (last_step) begin
          state_d = ST_IDLE;
          k_d     = 8'd0;
          c_d     = {step_b, step_a};
          done_d  = 1'b1;
        end else begin
          k_d     = k_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      done_q  <= 1'b0;
`ifdef RC5_CORE_DECRYPT_EN
      mode_q  <= 1'b0;
`endif
      for (int n = 0; n < NK; n++) begin
        sk_q[n] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      done_q  <= done_d;
`ifdef RC5_CORE_DECRYPT_EN
      mode_q  <= mode_d;
`endif
      sk_q    <= sk_d;
    end
  end

  assign c    = c_q;
  assign done = done_q;
  assign busy = (state_q == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_rc5_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_rc5_core
// Brief    : Self-checking bench for rc5_core against an arithmetic RC5 model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rc5_core;

  localparam int WB  = 16;
  localparam int RB  = 12;
  localparam int NKB = 2*RB+2;
  localparam int WS  = 8;
  localparam int RS  = 1;
  localparam int NKS = 2*RS+2;
`ifdef RC5_CORE_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        start_b = 1'b0, mode_b = 1'b0, sk_we_b = 1'b0;
  logic [31:0] p_b = '0;
  logic [31:0] c_b;
  logic        done_b, busy_b;
  logic [7:0]  sk_addr_b = '0;
  logic [15:0] sk_wdata_b = '0;

  logic        start_s = 1'b0, mode_s = 1'b0, sk_we_s = 1'b0;
  logic [15:0] p_s = '0;
  logic [15:0] c_s;
  logic        done_s, busy_s;
  logic [7:0]  sk_addr_s = '0;
  logic [7:0]  sk_wdata_s = '0;

  rc5_core #(.W(WB), .R(RB)) u_big (
    .clock(clock), .reset(reset), .start(start_b), .mode(mode_b), .p(p_b),
    .c(c_b), .done(done_b), .busy(busy_b),
    .sk_we(sk_we_b), .sk_addr(sk_addr_b), .sk_wdata(sk_wdata_b)
  );

  rc5_core #(.W(WS), .R(RS)) u_small (
    .clock(clock), .reset(reset), .start(start_s), .mode(mode_s), .p(p_s),
    .c(c_s), .done(done_s), .busy(busy_s),
    .sk_we(sk_we_s), .sk_addr(sk_addr_s), .sk_wdata(sk_wdata_s)
  );

  int checks   = 0;
  int failures = 0;
  int unsigned kb[];
  int unsigned ks[];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int unsigned rotl_m(input int unsigned x, input int unsigned n, input int w);
    int unsigned m;
    int unsigned s;
    m = (32'd1 << w) - 32'd1;
    s = n % w;
    if (s == 0) return x & m;
    return ((x << s) | (x >> (w - s))) & m;
  endfunction

  function automatic int unsigned rotr_m(input int unsigned x, input int unsigned n, input int w);
    return rotl_m(x, w - (n % w), w);
  endfunction

  function automatic logic [31:0] rc5_model(input bit dec, input int w, input int r,
                                            input logic [31:0] blk, input int unsigned s[]);
    int unsigned m, a, b;
    m = (32'd1 << w) - 32'd1;
    a = blk & m;
    b = (blk >> w) & m;
    if (!dec) begin
      a = (a + s[0]) & m;
      b = (b + s[1]) & m;
      for (int i = 1; i <= r; i++) begin
        a = (rotl_m(a ^ b, b, w) + s[2*i]) & m;
        b = (rotl_m(b ^ a, a, w) + s[2*i+1]) & m;
      end
    end else begin
      for (int i = r; i >= 1; i--) begin
        b = rotr_m((b - s[2*i+1]) & m, a, w) ^ a;
        a = rotr_m((a - s[2*i]) & m, b, w) ^ b;
      end
      b = (b - s[1]) & m;
      a = (a - s[0]) & m;
    end
    return (b << w) | a;
  endfunction

  function automatic logic obs_done(input bit sel);
    return sel ? done_s : done_b;
  endfunction
  function automatic logic obs_busy(input bit sel);
    return sel ? busy_s : busy_b;
  endfunction
  function automatic logic [31:0] obs_c(input bit sel);
    return sel ? {16'h0, c_s} : c_b;
  endfunction

  task automatic load_key(input bit sel, input int a, input int unsigned d);
    @(negedge clock);
    if (sel) begin
      sk_we_s = 1'b1; sk_addr_s = a[7:0]; sk_wdata_s = 8'(d);
    end else begin
      sk_we_b = 1'b1; sk_addr_b = a[7:0]; sk_wdata_b = 16'(d);
    end
    @(posedge clock); #1;
    sk_we_s = 1'b0;
    sk_we_b = 1'b0;
  endtask

  task automatic load_big_random;
    for (int i = 0; i < NKB; i++) begin
      kb[i] = $urandom_range(0, 65535);
      load_key(1'b0, i, kb[i]);
    end
  endtask

  // One full operation; optional key write on the accept edge; inputs scrambled during RUN.
  task automatic run_op(input bit sel, input bit m, input logic [31:0] pin,
                        input logic [31:0] exp, input string tag,
                        input bit kw = 1'b0, input int ka = 0, input int unsigned kd = 0);
    int lat, bad, want;
    want = sel ? RS + 1 : RB + 1;
    @(negedge clock);
    if (sel) begin
      start_s = 1'b1; mode_s = m; p_s = pin[15:0];
      sk_we_s = kw; sk_addr_s = ka[7:0]; sk_wdata_s = 8'(kd);
    end else begin
      start_b = 1'b1; mode_b = m; p_b = pin;
      sk_we_b = kw; sk_addr_b = ka[7:0]; sk_wdata_b = 16'(kd);
    end
    @(posedge clock); #1;
    start_s = 1'b0; start_b = 1'b0; sk_we_s = 1'b0; sk_we_b = 1'b0;
    p_s = 16'($urandom); p_b = $urandom; mode_s = ~m; mode_b = ~m;
    lat = 0;
    bad = 0;
    while (!obs_done(sel) && lat < 100) begin
      if (!obs_busy(sel)) bad++;
      @(posedge clock); #1;
      lat++;
    end
    check_eq({tag, ".lat"}, lat, want);
    check_eq({tag, ".busy_span"}, bad, 0);
    check_eq({tag, ".busy_end"}, 32'(obs_busy(sel)), 32'd0);
    check_eq({tag, ".c"}, obs_c(sel), exp);
    @(posedge clock); #1;
    check_eq({tag, ".pulse"}, 32'(obs_done(sel)), 32'd0);
  endtask

  initial begin : main
    logic [31:0] pt, ct, exp;
    int          ndone, n;
    int          q[$];

    kb = new[NKB];
    ks = new[NKS];

    reset = 1'b1;
    #12;
    check_eq("rst.c_big",    c_b, 32'd0);
    check_eq("rst.busy_big", 32'(busy_b), 32'd0);
    check_eq("rst.done_big", 32'(done_b), 32'd0);
    check_eq("rst.c_small",  {16'h0, c_s}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Known vector on the W=8, R=1 instance
    ks[0] = 1; ks[1] = 2; ks[2] = 0; ks[3] = 0;
    for (int i = 0; i < NKS; i++) load_key(1'b1, i, ks[i]);
    run_op(1'b1, 1'b0, 32'h0000, 32'h0000E00C, "kv_enc");
    run_op(1'b1, 1'b1, 32'h0000E00C,
           DEC_EN ? 32'h0 : rc5_model(1'b0, WS, RS, 32'h0000E00C, ks), "kv_dec");
    run_op(1'b1, 1'b1, 32'h0000,
           DEC_EN ? rc5_model(1'b1, WS, RS, 32'h0, ks) : 32'h0000E00C, "kv_mode1");

    // Random keys and blocks: encrypt, then run the ciphertext with mode=1
    for (int it = 0; it < 200; it++) begin
      load_big_random();
      pt = $urandom;
      ct = rc5_model(1'b0, WB, RB, pt, kb);
      run_op(1'b0, 1'b0, pt, ct, "rnd_enc");
      exp = DEC_EN ? pt : rc5_model(1'b0, WB, RB, ct, kb);
      run_op(1'b0, 1'b1, ct, exp, "rnd_dec");
    end

    // start held for 5 cycles during RUN
    pt = $urandom;
    @(negedge clock);
    start_b = 1'b1; mode_b = 1'b0; p_b = pt;
    @(posedge clock); #1;
    start_b = 1'b0;
    ndone = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      start_b = (cyc >= 2 && cyc < 7);
      @(posedge clock); #1;
      if (done_b) begin
        ndone++;
        check_eq("hold5.c", c_b, rc5_model(1'b0, WB, RB, pt, kb));
      end
    end
    start_b = 1'b0;
    check_eq("hold5.ndone", ndone, 1);

    // start held continuously: accepts spaced R+2 apart
    pt = $urandom;
    @(negedge clock);
    start_b = 1'b1; mode_b = 1'b0; p_b = pt;
    for (int cyc = 0; cyc < 45; cyc++) begin
      @(posedge clock); #1;
      if (done_b) begin
        q.push_back(cyc);
        check_eq("cont.c", c_b, rc5_model(1'b0, WB, RB, pt, kb));
      end
    end
    start_b = 1'b0;
    check_eq("cont.ndone", q.size(), 3);
    check_eq("cont.gap1", q[1] - q[0], RB + 2);
    check_eq("cont.gap2", q[2] - q[1], RB + 2);
    n = 0;
    while (busy_b && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    check_eq("cont.drain", 32'(busy_b), 32'd0);

    // Key write while busy is dropped
    pt = $urandom;
    exp = rc5_model(1'b0, WB, RB, pt, kb);
    @(negedge clock);
    start_b = 1'b1; mode_b = 1'b0; p_b = pt;
    @(posedge clock); #1;
    start_b = 1'b0;
    sk_we_b = 1'b1; sk_addr_b = 8'd0; sk_wdata_b = ~16'(kb[0]);
    @(posedge clock); #1;
    sk_we_b = 1'b0;
    n = 0;
    while (!done_b && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    check_eq("bw.done", 32'(done_b), 32'd1);
    check_eq("bw.c", c_b, exp);
    pt = $urandom;
    run_op(1'b0, 1'b0, pt, rc5_model(1'b0, WB, RB, pt, kb), "bw_after");

    // Out-of-range address dropped
    load_key(1'b0, NKB, $urandom_range(0, 65535));
    load_key(1'b0, 255, $urandom_range(0, 65535));
    pt = $urandom;
    run_op(1'b0, 1'b0, pt, rc5_model(1'b0, WB, RB, pt, kb), "oor");

    // Key write on the accept edge takes effect for that operation
    kb[1] = $urandom_range(0, 65535);
    pt = $urandom;
    run_op(1'b0, 1'b0, pt, rc5_model(1'b0, WB, RB, pt, kb), "acc_wr", 1'b1, 1, kb[1]);

    // Asynchronous reset mid-RUN
    pt = $urandom;
    @(negedge clock);
    start_b = 1'b1; mode_b = 1'b0; p_b = pt;
    @(posedge clock); #1;
    start_b = 1'b0;
    repeat (4) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check_eq("amr.busy", 32'(busy_b), 32'd0);
    check_eq("amr.done", 32'(done_b), 32'd0);
    check_eq("amr.c", c_b, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    ndone = 0;
    repeat (20) begin
      @(posedge clock); #1;
      if (done_b) ndone++;
    end
    check_eq("amr.ndone", ndone, 0);
    check_eq("amr.c_hold", c_b, 32'd0);
    load_big_random();
    pt = $urandom;
    run_op(1'b0, 1'b0, pt, rc5_model(1'b0, WB, RB, pt, kb), "amr_fresh");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
